instruction_fetch_stage: RTL and testbench
==========================================

# instruction_fetch_stage

Fetch stage of the RV64 pipeline: owns the program counter, drives the byte address into `Instruction_Memory`, and captures the returned 32-bit word into the IF/ID pipeline register. It handles stalls from the hazard unit, branch/jump redirects from EX, end-of-program halt and misaligned-target trapping. `Instruction_Memory` is purely combinational, so the fetched word is valid in the same cycle the address is driven.

## Interface
- `RESET_PC`, 64'd0, PC loaded on reset
- `MEM_BYTES`, 148, size of instruction memory in bytes; a fetch is legal only if PC+4 ≤ MEM_BYTES
- `NOP_INST`, 32'h00000013, bubble word (addi x0,x0,0) placed in IF/ID on flush/halt
- `clk` in 1: single clock; all state updates on rising edge
- `reset` in 1: synchronous, active-high
- `Stall` in 1: hold PC and IF/ID this cycle
- `Branch_Taken` in 1: redirect PC this cycle
- `Branch_Target` in 64: redirect byte address
- `Inst_Address` out 64: to `Instruction_Memory`; equals PC register (combinational from PC)
- `Instruction` in 32: from `Instruction_Memory`, same cycle
- `IFID_PC` out 64: registered PC of captured instruction
- `IFID_Instruction` out 32: registered instruction word
- `IFID_Valid` out 1: IF/ID holds a real instruction
- `Fetch_Done` out 1: registered; high in HALT
- `Misaligned` out 1: registered; high in TRAP

## Operation
- States: RUN, HALT, TRAP (2-bit register). `Fetch_Done` = (state==HALT), `Misaligned` = (state==TRAP).
- Priority each edge: reset > Branch_Taken > Stall > normal fetch.
- reset: PC←RESET_PC, state←RUN, IFID_PC←0, IFID_Instruction←NOP_INST, IFID_Valid←0. Overrides Stall/Branch_Taken in the same cycle.
- Branch_Taken, state RUN or HALT, Branch_Target[1:0]==0: PC←Branch_Target, state←RUN, IF/ID flushed (NOP_INST, Valid 0, IFID_PC←0). Wins over Stall.
- Branch_Taken, Branch_Target[1:0]≠0: PC unchanged, IF/ID flushed, state←TRAP.
- TRAP: PC and IF/ID frozen at flushed values; Branch_Taken and Stall ignored; exits only on reset.
- RUN, !Stall, in-range (PC+4 ≤ MEM_BYTES, compared at 65 bits so no wrap): IFID_PC←PC, IFID_Instruction←Instruction, IFID_Valid←1, PC←PC+4 (64-bit, wrap ignored).
- RUN, !Stall, out-of-range: PC held, IF/ID flushed, state←HALT.
- RUN or HALT with Stall, no branch: PC, IF/ID, state all hold.
- HALT, !Stall, no branch: IF/ID flushed, PC held.
- Aligned branch to an out-of-range target enters RUN; next unstalled edge moves to HALT with a bubble (no memory word captured).
- `Inst_Address` always reflects PC, even in HALT/TRAP. The memory word is not captured in those states, so out-of-range reads are don't-care.

## Timing
- All outputs except `Inst_Address` are registered. Reset values: Inst_Address=RESET_PC, IFID_PC=0, IFID_Instruction=NOP_INST, IFID_Valid=0, Fetch_Done=0, Misaligned=0.
- Fetch latency: 1 cycle. The word at address A appears on IF/ID the edge after Inst_Address=A with Stall low.
- First valid instruction: first edge after reset deasserts.
- Redirect: one bubble. The redirect edge loads PC and flushes; the target instruction lands on the next unstalled edge.
- Stall holds indefinitely with no loss or duplication of instructions.
- Throughput: one instruction per cycle when unstalled.

## Test plan
- Reset release with program loaded: edge1 → IFID_PC=0, IFID_Instruction=0x00600593, Valid=1, Inst_Address=4. Edge2 → IFID_PC=4, IFID_Instruction=0x00600E93.
- Stall high for 2 cycles while Inst_Address=8: IF/ID stays {4, 0x00600E93, 1} and Inst_Address stays 8. Stall low → IFID_PC=8, IFID_Instruction=0x00000F13.
- Branch_Taken=1, Branch_Target=0x24, Stall=1 in the same cycle: next edge Inst_Address=0x24, IFID_Valid=0, IFID_Instruction=0x00000013. Following edge IFID_PC=0x24, IFID_Instruction=0x01FE0463.
- Branch to 0x90: edge → PC=0x90. Edge → IFID_Instruction=0xFC0006E3, PC=0x94. Edge → Fetch_Done=1, Valid=0, Inst_Address=0x94. Branch to 0 → Fetch_Done=0, and the edge after that yields IFID_Instruction=0x00600593.
- Branch_Target=0x26: next edge Misaligned=1, Valid=0, PC unchanged. A later branch to 0 and Stall toggling have no effect. reset → Misaligned=0, PC=0.
- reset asserted mid-run with Stall=1 and Branch_Taken=1 (target 0x40): next edge shows all reset values and state RUN.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// ============================================================================
// Module      : instruction_fetch_stage
// Description : RV64 fetch stage. Owns the PC, drives the combinational
//               instruction memory address, and captures the returned word
//               into the IF/ID register. Handles stall, redirect, halt at the
//               end of the program image, and misaligned-target trapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter int unsigned MEM_BYTES = 148,
    parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Branch_Taken,
    input  logic [63:0] Branch_Target,
    output logic [63:0] Inst_Address,
    input  logic [31:0] Instruction,
    output logic [63:0] IFID_PC,
    output logic [31:0] IFID_Instruction,
    output logic        IFID_Valid,
    output logic        Fetch_Done,
    output logic        Misaligned
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        TRAP = 2'd2
    } state_t;

    localparam logic [64:0] MEM_LIMIT = 65'(MEM_BYTES);

    state_t      state;
    logic [63:0] pc;
    logic        in_range;
    logic        target_aligned;

    // The memory is combinational, so the address is simply the PC.
    assign Inst_Address = pc;

    // Range check is done one bit wider so a PC near 2^64 cannot wrap into range.
    assign in_range       = ({1'b0, pc} + 65'd4) <= MEM_LIMIT;
    assign target_aligned = (Branch_Target[1:0] == 2'b00);

    // PC, IF/ID register and fetch FSM; priority reset > trap freeze > branch > stall > fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc               <= RESET_PC;
            state            <= RUN;
            IFID_PC          <= 64'd0;
            IFID_Instruction <= NOP_INST;
            IFID_Valid       <= 1'b0;
            Fetch_Done       <= 1'b0;
            Misaligned       <= 1'b0;
        end else if (state == TRAP) begin
            // Frozen until reset: IF/ID was already flushed on trap entry.
            pc               <= pc;
        end else if (Branch_Taken) begin
            // Any redirect flushes the word currently in IF/ID.
            IFID_PC          <= 64'd0;
            IFID_Instruction <= NOP_INST;
            IFID_Valid       <= 1'b0;
            if (target_aligned) begin
                pc         <= Branch_Target;
                state      <= RUN;
                Fetch_Done <= 1'b0;
                Misaligned <= 1'b0;
            end else begin
                state      <= TRAP;
                Fetch_Done <= 1'b0;
                Misaligned <= 1'b1;
            end
        end else if (Stall) begin
            // Hold everything so no instruction is lost or duplicated.
            pc               <= pc;
        end else if (state == RUN) begin
            if (in_range) begin
                IFID_PC          <= pc;
                IFID_Instruction <= Instruction;
                IFID_Valid       <= 1'b1;
                pc               <= pc + 64'd4;
            end else begin
                // Past the end of the program image: park here and emit bubbles.
                IFID_PC          <= 64'd0;
                IFID_Instruction <= NOP_INST;
                IFID_Valid       <= 1'b0;
                state            <= HALT;
                Fetch_Done       <= 1'b1;
                Misaligned       <= 1'b0;
            end
        end else begin
            // HALT with no redirect keeps feeding bubbles.
            IFID_PC          <= 64'd0;
            IFID_Instruction <= NOP_INST;
            IFID_Valid       <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
// ============================================================================
// Module      : tb_instruction_fetch_stage
// Description : Directed self-checking bench for instruction_fetch_stage with
//               a small combinational instruction memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        Stall;
    logic        Branch_Taken;
    logic [63:0] Branch_Target;
    logic [63:0] Inst_Address;
    logic [31:0] Instruction;
    logic [63:0] IFID_PC;
    logic [31:0] IFID_Instruction;
    logic        IFID_Valid;
    logic        Fetch_Done;
    logic        Misaligned;

    int checks;
    int errors;

    logic [31:0] mem [0:36];

    instruction_fetch_stage #(
        .RESET_PC  (64'd0),
        .MEM_BYTES (148),
        .NOP_INST  (NOP)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .Stall            (Stall),
        .Branch_Taken     (Branch_Taken),
        .Branch_Target    (Branch_Target),
        .Inst_Address     (Inst_Address),
        .Instruction      (Instruction),
        .IFID_PC          (IFID_PC),
        .IFID_Instruction (IFID_Instruction),
        .IFID_Valid       (IFID_Valid),
        .Fetch_Done       (Fetch_Done),
        .Misaligned       (Misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory; out-of-range reads return a marker word.
    always_comb begin
        Instruction = 32'hDEAD_BEEF;
        if (Inst_Address < 64'd148)
            Instruction = mem[Inst_Address[7:2]];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_addr"},  Inst_Address, 64'd0);
        check({tag, "_pc"},    IFID_PC, 64'd0);
        check({tag, "_inst"},  64'(IFID_Instruction), 64'(NOP));
        check({tag, "_valid"}, 64'(IFID_Valid), 64'd0);
        check({tag, "_done"},  64'(Fetch_Done), 64'd0);
        check({tag, "_mis"},   64'(Misaligned), 64'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 37; i++) mem[i] = 32'h1000_0000 | 32'(i);
        mem[0]  = 32'h0060_0593;
        mem[1]  = 32'h0060_0E93;
        mem[2]  = 32'h0000_0F13;
        mem[9]  = 32'h01FE_0463;
        mem[36] = 32'hFC00_06E3;

        reset = 1'b1; Stall = 1'b0; Branch_Taken = 1'b0; Branch_Target = 64'd0;
        step();
        step();
        check_reset_values("rst");

        // Reset release: one instruction per edge.
        reset = 1'b0;
        step();
        check("e1_pc", IFID_PC, 64'd0);
        check("e1_inst", 64'(IFID_Instruction), 64'h0060_0593);
        check("e1_valid", 64'(IFID_Valid), 64'd1);
        check("e1_addr", Inst_Address, 64'd4);
        step();
        check("e2_pc", IFID_PC, 64'd4);
        check("e2_inst", 64'(IFID_Instruction), 64'h0060_0E93);

        // Two stalled cycles hold everything.
        Stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_pc", IFID_PC, 64'd4);
            check("stall_inst", 64'(IFID_Instruction), 64'h0060_0E93);
            check("stall_valid", 64'(IFID_Valid), 64'd1);
            check("stall_addr", Inst_Address, 64'd8);
        end
        Stall = 1'b0;
        step();
        check("unstall_pc", IFID_PC, 64'd8);
        check("unstall_inst", 64'(IFID_Instruction), 64'h0000_0F13);

        // Branch wins over a simultaneous stall.
        Branch_Taken = 1'b1; Branch_Target = 64'h24; Stall = 1'b1;
        step();
        check("br_addr", Inst_Address, 64'h24);
        check("br_valid", 64'(IFID_Valid), 64'd0);
        check("br_inst", 64'(IFID_Instruction), 64'(NOP));
        Branch_Taken = 1'b0; Stall = 1'b0;
        step();
        check("tgt_pc", IFID_PC, 64'h24);
        check("tgt_inst", 64'(IFID_Instruction), 64'h01FE_0463);

        // Last word in memory, then halt.
        Branch_Taken = 1'b1; Branch_Target = 64'h90;
        step();
        check("b90_addr", Inst_Address, 64'h90);
        Branch_Taken = 1'b0;
        step();
        check("last_inst", 64'(IFID_Instruction), 64'hFC00_06E3);
        check("last_pc", IFID_PC, 64'h90);
        check("last_addr", Inst_Address, 64'h94);
        step();
        check("halt_done", 64'(Fetch_Done), 64'd1);
        check("halt_valid", 64'(IFID_Valid), 64'd0);
        check("halt_addr", Inst_Address, 64'h94);
        check("halt_inst", 64'(IFID_Instruction), 64'(NOP));
        step();
        check("halt_hold", 64'(Fetch_Done), 64'd1);
        Branch_Taken = 1'b1; Branch_Target = 64'h0;
        step();
        check("unhalt_done", 64'(Fetch_Done), 64'd0);
        check("unhalt_addr", Inst_Address, 64'd0);
        Branch_Taken = 1'b0;
        step();
        check("unhalt_inst", 64'(IFID_Instruction), 64'h0060_0593);

        // Misaligned target traps and freezes.
        Branch_Taken = 1'b1; Branch_Target = 64'h26;
        step();
        check("trap_mis", 64'(Misaligned), 64'd1);
        check("trap_valid", 64'(IFID_Valid), 64'd0);
        check("trap_addr", Inst_Address, 64'd4);
        Branch_Target = 64'h0;
        step();
        Branch_Taken = 1'b0; Stall = 1'b1;
        step();
        Stall = 1'b0;
        step();
        check("frz_mis", 64'(Misaligned), 64'd1);
        check("frz_addr", Inst_Address, 64'd4);
        check("frz_valid", 64'(IFID_Valid), 64'd0);
        check("frz_done", 64'(Fetch_Done), 64'd0);
        reset = 1'b1;
        step();
        check("trst_mis", 64'(Misaligned), 64'd0);
        check("trst_addr", Inst_Address, 64'd0);

        // Aligned branch to an out-of-range target: RUN, then halt with a bubble.
        reset = 1'b0; Branch_Taken = 1'b1; Branch_Target = 64'h100;
        step();
        check("oor_addr", Inst_Address, 64'h100);
        check("oor_done0", 64'(Fetch_Done), 64'd0);
        Branch_Taken = 1'b0;
        step();
        check("oor_done1", 64'(Fetch_Done), 64'd1);
        check("oor_valid", 64'(IFID_Valid), 64'd0);
        check("oor_inst", 64'(IFID_Instruction), 64'(NOP));

        // PC near 2^64 must not wrap into range.
        Branch_Taken = 1'b1; Branch_Target = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        Branch_Taken = 1'b0;
        step();
        check("wrap_done", 64'(Fetch_Done), 64'd1);
        check("wrap_valid", 64'(IFID_Valid), 64'd0);
        check("wrap_addr", Inst_Address, 64'hFFFF_FFFF_FFFF_FFFC);

        // Reset mid-run overrides stall and branch.
        Branch_Taken = 1'b1; Branch_Target = 64'h0;
        step();
        Branch_Taken = 1'b0;
        step();
        step();
        check("mid_pc", IFID_PC, 64'd4);
        reset = 1'b1; Stall = 1'b1; Branch_Taken = 1'b1; Branch_Target = 64'h40;
        step();
        check_reset_values("mrst");
        reset = 1'b0; Stall = 1'b0; Branch_Taken = 1'b0;
        step();
        check("mrst_run_inst", 64'(IFID_Instruction), 64'h0060_0593);
        check("mrst_run_valid", 64'(IFID_Valid), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
